// File: rtl/soc_bus_arbiter_pkg.sv
// Shared definitions for the CPU-subsystem bus arbiter and its address decoder.
package soc_bus_pkg;

  typedef enum logic [1:0] {
    ST_IDLE   = 2'd0,
    ST_ACCESS = 2'd1,
    ST_RESP   = 2'd2
  } bus_state_e;

  // Slave select bit positions in s_sel / s_ack
  localparam int unsigned SLV_IMEM  = 0;
  localparam int unsigned SLV_DMEM  = 1;
  localparam int unsigned SLV_ASCON = 2;

  // Master index positions in the m_* vectors
  localparam int unsigned M_IF   = 0;
  localparam int unsigned M_DATA = 1;

  // Read data returned alongside a bus error
  localparam logic [31:0] ERR_DATA = 32'h0;

endpackage

// File: rtl/soc_bus_arbiter_address_decoder.sv
// Maps a 32-bit bus address onto a one-hot slave select:
// IMEM 0x0000_0xxx, DMEM 0x0000_1xxx, ASCON 0x1000_00xx.
module address_decoder
  import soc_bus_pkg::*;
(
  input  logic [31:0] addr_i,
  output logic [2:0]  sel_o,
  output logic        valid_o
);

  // Range match; anything outside the three windows is an invalid address
  always_comb begin
    sel_o = '0;
    if (addr_i[31:12] == 20'h00000) begin
      sel_o[SLV_IMEM] = 1'b1;
    end else if (addr_i[31:12] == 20'h00001) begin
      sel_o[SLV_DMEM] = 1'b1;
    end else if (addr_i[31:8] == 24'h100000) begin
      sel_o[SLV_ASCON] = 1'b1;
    end
    valid_o = |sel_o;
  end

endmodule

// File: rtl/soc_bus_arbiter.sv
// Two-master / three-slave bus controller: round-robin arbitration between
// the fetch (M0) and data (M1) ports, single outstanding transaction, with
// bus error on invalid address or slave timeout.
module soc_bus_arbiter
  import soc_bus_pkg::*;
#(
  parameter int unsigned DATA_W         = 32,
  parameter int unsigned TIMEOUT_CYCLES = 16,
  parameter int unsigned TO_CNT_W       = 5
) (
  input  logic                clk,
  input  logic                rst_n,
  input  logic [1:0]          m_req,
  input  logic [63:0]         m_addr,
  input  logic [1:0]          m_we,
  input  logic [2*DATA_W-1:0] m_wdata,
  input  logic [7:0]          m_wstrb,
  output logic [1:0]          m_gnt,
  output logic [1:0]          m_rsp_valid,
  output logic                m_rsp_err,
  output logic [DATA_W-1:0]   m_rdata,
  output logic                s_valid,
  output logic [2:0]          s_sel,
  output logic [31:0]         s_addr,
  output logic                s_we,
  output logic [DATA_W-1:0]   s_wdata,
  output logic [3:0]          s_wstrb,
  input  logic [2:0]          s_ack,
  input  logic [DATA_W-1:0]   s_rdata_imem,
  input  logic [DATA_W-1:0]   s_rdata_dmem,
  input  logic [DATA_W-1:0]   s_rdata_ascon
);

  bus_state_e          state_q;
  logic                owner_q;
  logic                last_owner_q;
  logic [TO_CNT_W-1:0] to_cnt_q;
  logic                s_valid_q;
  logic [2:0]          s_sel_q;
  logic [31:0]         s_addr_q;
  logic                s_we_q;
  logic [DATA_W-1:0]   s_wdata_q;
  logic [3:0]          s_wstrb_q;
  logic [1:0]          rsp_valid_q;
  logic                rsp_err_q;
  logic [DATA_W-1:0]   rdata_q;

  logic                win_d;
  logic                gnt_any;
  logic [31:0]         win_addr;
  logic                win_we;
  logic [DATA_W-1:0]   win_wdata;
  logic [3:0]          win_wstrb;
  logic [2:0]          dec_sel;
  logic                dec_valid;
  logic                ack_hit;
  logic                timeout_hit;
  logic [DATA_W-1:0]   slv_rdata;

  // Round-robin winner and payload mux; gnt is also gated by reset so it
  // drops together with the asynchronously cleared registers
  always_comb begin
    if (m_req == 2'b11) begin
      win_d = ~last_owner_q;
    end else begin
      win_d = m_req[M_DATA];
    end
    gnt_any   = rst_n && (state_q == ST_IDLE) && (|m_req);
    m_gnt     = gnt_any ? {win_d, ~win_d} : '0;
    win_addr  = win_d ? m_addr[63:32]             : m_addr[31:0];
    win_we    = win_d ? m_we[M_DATA]              : m_we[M_IF];
    win_wdata = win_d ? m_wdata[2*DATA_W-1:DATA_W] : m_wdata[DATA_W-1:0];
    win_wstrb = win_d ? m_wstrb[7:4]              : m_wstrb[3:0];
  end

  address_decoder u_dec (
    .addr_i  (win_addr),
    .sel_o   (dec_sel),
    .valid_o (dec_valid)
  );

  // Completion detection for the selected slave and its read data
  always_comb begin
    ack_hit     = |(s_ack & s_sel_q);
    timeout_hit = (to_cnt_q == TO_CNT_W'(TIMEOUT_CYCLES - 1));
    slv_rdata   = '0;
    if (s_sel_q[SLV_IMEM]) begin
      slv_rdata = s_rdata_imem;
    end else if (s_sel_q[SLV_DMEM]) begin
      slv_rdata = s_rdata_dmem;
    end else if (s_sel_q[SLV_ASCON]) begin
      slv_rdata = s_rdata_ascon;
    end
  end

  // Transaction sequencer with registered slave-side and response outputs
  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      state_q      <= ST_IDLE;
      owner_q      <= 1'b0;
      last_owner_q <= 1'b1;
      to_cnt_q     <= '0;
      s_valid_q    <= 1'b0;
      s_sel_q      <= '0;
      s_addr_q     <= '0;
      s_we_q       <= 1'b0;
      s_wdata_q    <= '0;
      s_wstrb_q    <= '0;
      rsp_valid_q  <= '0;
      rsp_err_q    <= 1'b0;
      rdata_q      <= '0;
    end else begin
      rsp_valid_q <= '0;
      case (state_q)
        ST_IDLE: begin
          if (gnt_any) begin
            owner_q      <= win_d;
            last_owner_q <= win_d;
            s_addr_q     <= win_addr;
            s_we_q       <= win_we;
            s_wdata_q    <= win_wdata;
            s_wstrb_q    <= win_wstrb;
            to_cnt_q     <= '0;
            if (dec_valid) begin
              state_q   <= ST_ACCESS;
              s_valid_q <= 1'b1;
              s_sel_q   <= dec_sel;
            end else begin
              state_q     <= ST_RESP;
              rsp_valid_q <= {win_d, ~win_d};
              rsp_err_q   <= 1'b1;
              rdata_q     <= DATA_W'(ERR_DATA);
            end
          end
        end
        ST_ACCESS: begin
          if (ack_hit || timeout_hit) begin
            state_q     <= ST_RESP;
            s_valid_q   <= 1'b0;
            s_sel_q     <= '0;
            rsp_valid_q <= {owner_q, ~owner_q};
            // ack takes priority over a coincident timeout
            rsp_err_q   <= ~ack_hit;
            rdata_q     <= (ack_hit && !s_we_q) ? slv_rdata : DATA_W'(ERR_DATA);
          end else begin
            to_cnt_q <= to_cnt_q + TO_CNT_W'(1);
          end
        end
        ST_RESP: begin
          state_q <= ST_IDLE;
        end
        default: begin
          state_q <= ST_IDLE;
        end
      endcase
    end
  end

  assign m_rsp_valid = rsp_valid_q;
  assign m_rsp_err   = rsp_err_q;
  assign m_rdata     = rdata_q;
  assign s_valid     = s_valid_q;
  assign s_sel       = s_sel_q;
  assign s_addr      = s_addr_q;
  assign s_we        = s_we_q;
  assign s_wdata     = s_wdata_q;
  assign s_wstrb     = s_wstrb_q;

`ifndef SYNTHESIS
  // Simulation-only guard on the one-hot outputs
  always_ff @(posedge clk) begin
    if (rst_n) begin
      assert ($onehot0(m_gnt)) else $error("m_gnt not one-hot: %b", m_gnt);
      assert ($onehot0(m_rsp_valid)) else $error("m_rsp_valid not one-hot: %b", m_rsp_valid);
      assert ($onehot0(s_sel)) else $error("s_sel not one-hot: %b", s_sel);
    end
  end
`endif

endmodule
